// File: rtl/wb_project_select_pkg.sv
// Shared definitions for the Wishbone project selector.
// Holds register offsets, the ID constant, CTRL/STATUS field positions,
// the selector FSM state type and a byte-lane merge helper.
package wb_project_select_pkg;

    // Register offsets, decoded from wbs_adr_i[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_GUARD  = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_ID     = 2'd3;

    localparam logic [31:0] ID_VALUE = 32'h5052_4A53;

    // CTRL field positions
    localparam int CTRL_IDX_LSB   = 0;
    localparam int CTRL_EN_BIT    = 8;
    localparam int CTRL_IRQEN_BIT = 9;

    // STATUS field positions
    localparam int STAT_CUR_LSB  = 0;
    localparam int STAT_ON_BIT   = 8;
    localparam int STAT_BUSY_BIT = 9;
    localparam int STAT_INV_BIT  = 10;
    localparam int STAT_CNT_LSB  = 16;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    // Replace only the bytes whose lane-enable bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_reg_slave.sv
// Wishbone register slave for the project selector.
// Decodes the 16-byte window, generates a one-cycle ack, performs byte-lane
// writes to CTRL/GUARD and registers the read data alongside the ack.
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_cyc, i_stb, i_we, i_sel,   Wishbone request
//   i_adr, i_dat
//   o_ack, o_dat                 Wishbone response (o_dat is 0 whenever o_ack is 0)
//   i_status                     STATUS word supplied by the selector FSM
//   o_idx, o_enable, o_irq_en    CTRL fields
//   o_guard                      GUARD register
//   o_ctrl_chg                   one-cycle pulse after a CTRL commit that changed idx or enable
//
// Handshake: a request is cyc & stb & in-window & ~ack. It is answered by
// ack on the next edge for exactly one cycle; writes commit on that same
// edge. Because ack masks the request, ack never stays high two cycles.
module wb_reg_slave
    import wb_project_select_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [7:0]  RESET_GUARD = 8'd4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cyc,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_dat,
    output logic        o_ack,
    output logic [31:0] o_dat,
    input  logic [31:0] i_status,
    output logic [3:0]  o_idx,
    output logic        o_enable,
    output logic        o_irq_en,
    output logic [7:0]  o_guard,
    output logic        o_ctrl_chg
);

    logic        r_ack;
    logic [31:0] r_dat;
    logic [3:0]  r_idx;
    logic        r_enable;
    logic        r_irq_en;
    logic [7:0]  r_guard;
    logic        r_ctrl_chg;

    logic        w_hit;
    logic        w_req;
    logic [1:0]  w_off;
    logic [31:0] w_ctrl_rd;
    logic [31:0] w_ctrl_new;
    logic [31:0] w_guard_new;
    logic [31:0] w_rd_data;
    logic        w_unused;

    assign w_hit = (i_adr[31:4] == BASE_ADDR[31:4]);
    assign w_req = i_cyc & i_stb & ~r_ack & w_hit;
    assign w_off = i_adr[3:2];

    always_comb begin
        w_ctrl_rd = '0;
        w_ctrl_rd[CTRL_IDX_LSB +: 4] = r_idx;
        w_ctrl_rd[CTRL_EN_BIT]       = r_enable;
        w_ctrl_rd[CTRL_IRQEN_BIT]    = r_irq_en;
    end

    assign w_ctrl_new  = byte_merge(w_ctrl_rd, i_dat, i_sel);
    assign w_guard_new = byte_merge({24'd0, r_guard}, i_dat, i_sel);

    // Bits that have no storage behind them
    assign w_unused = ^{i_adr[1:0], w_ctrl_new[31:10], w_ctrl_new[7:4], w_guard_new[31:8]};

    always_comb begin
        w_rd_data = '0;
        case (w_off)
            REG_CTRL:   w_rd_data = w_ctrl_rd;
            REG_GUARD:  w_rd_data = {24'd0, r_guard};
            REG_STATUS: w_rd_data = i_status;
            REG_ID:     w_rd_data = ID_VALUE;
            default:    w_rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_idx      <= '0;
            r_enable   <= 1'b0;
            r_irq_en   <= 1'b0;
            r_guard    <= RESET_GUARD;
            r_ctrl_chg <= 1'b0;
        end else begin
            r_ack      <= w_req;
            r_dat      <= '0;
            r_ctrl_chg <= 1'b0;
            if (w_req) begin
                if (!i_we) begin
                    r_dat <= w_rd_data;
                end else begin
                    case (w_off)
                        REG_CTRL: begin
                            r_idx      <= w_ctrl_new[CTRL_IDX_LSB +: 4];
                            r_enable   <= w_ctrl_new[CTRL_EN_BIT];
                            r_irq_en   <= w_ctrl_new[CTRL_IRQEN_BIT];
                            // irq_en alone is not a target change
                            r_ctrl_chg <= (w_ctrl_new[CTRL_IDX_LSB +: 4] != r_idx) ||
                                          (w_ctrl_new[CTRL_EN_BIT] != r_enable);
                        end
                        REG_GUARD: r_guard <= w_guard_new[7:0];
                        default: ;  // STATUS and ID are read-only
                    endcase
                end
            end
        end
    end

    assign o_ack      = r_ack;
    assign o_dat      = r_dat;
    assign o_idx      = r_idx;
    assign o_enable   = r_enable;
    assign o_irq_en   = r_irq_en;
    assign o_guard    = r_guard;
    assign o_ctrl_chg = r_ctrl_chg;

endmodule

// File: rtl/wb_project_select.sv
// Project selector: enables exactly one wrapped project at a time, with a
// programmable all-zero guard interval between deselecting one project and
// selecting the next.
// Ports:
//   wb_clk_i, wb_rst_n      clock, async active-low reset
//   wbs_*                   Wishbone slave (CTRL, GUARD, STATUS, ID)
//   active_o                one-hot project enable, all-zero outside ON
//   irq_o                   one-cycle pulse when a switch completes (if irq_en)
// The FSM state is visible through STATUS.on / STATUS.busy.
module wb_project_select
    import wb_project_select_pkg::*;
#(
    parameter int          NUM_PROJECTS = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter logic [7:0]  RESET_GUARD  = 8'd4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_PROJECTS-1:0] active_o,
    output logic                    irq_o
);

    logic [3:0]  w_idx;
    logic        w_enable;
    logic        w_irq_en;
    logic [7:0]  w_guard;
    logic        w_ctrl_chg;
    logic        w_idx_ok;
    logic        w_valid;
    logic [31:0] w_status;

    state_t      r_state,        w_state_nxt;
    logic [7:0]  r_counter,      w_counter_nxt;
    logic [3:0]  r_cur_idx,      w_cur_idx_nxt;
    logic [15:0] r_switch_count, w_switch_count_nxt;
    logic        r_irq,          w_irq_nxt;
    logic [NUM_PROJECTS-1:0] w_active;

    wb_reg_slave #(
        .BASE_ADDR   (BASE_ADDR),
        .RESET_GUARD (RESET_GUARD)
    ) u_regs (
        .i_clk      (wb_clk_i),
        .i_rst_n    (wb_rst_n),
        .i_cyc      (wbs_cyc_i),
        .i_stb      (wbs_stb_i),
        .i_we       (wbs_we_i),
        .i_sel      (wbs_sel_i),
        .i_adr      (wbs_adr_i),
        .i_dat      (wbs_dat_i),
        .o_ack      (wbs_ack_o),
        .o_dat      (wbs_dat_o),
        .i_status   (w_status),
        .o_idx      (w_idx),
        .o_enable   (w_enable),
        .o_irq_en   (w_irq_en),
        .o_guard    (w_guard),
        .o_ctrl_chg (w_ctrl_chg)
    );

    assign w_idx_ok = ({28'd0, w_idx} < NUM_PROJECTS);
    assign w_valid  = w_enable & w_idx_ok;

    always_comb begin
        w_status = '0;
        w_status[STAT_CUR_LSB +: 4]  = r_cur_idx;
        w_status[STAT_ON_BIT]        = (r_state == ST_ON);
        w_status[STAT_BUSY_BIT]      = (r_state == ST_DRAIN);
        w_status[STAT_INV_BIT]       = w_enable & ~w_idx_ok;
        w_status[STAT_CNT_LSB +: 16] = r_switch_count;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state        <= ST_OFF;
            r_counter      <= '0;
            r_cur_idx      <= '0;
            r_switch_count <= '0;
            r_irq          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_counter      <= w_counter_nxt;
            r_cur_idx      <= w_cur_idx_nxt;
            r_switch_count <= w_switch_count_nxt;
            r_irq          <= w_irq_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_counter_nxt      = r_counter;
        w_cur_idx_nxt      = r_cur_idx;
        w_switch_count_nxt = r_switch_count;
        w_irq_nxt          = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_valid) begin
                    w_state_nxt   = ST_DRAIN;
                    w_counter_nxt = w_guard;
                end
            end
            ST_DRAIN: begin
                // A change of target restarts the guard interval; an
                // invalid target abandons the switch altogether.
                if (!w_valid) begin
                    w_state_nxt   = ST_OFF;
                    w_counter_nxt = '0;
                end else if (w_ctrl_chg) begin
                    w_counter_nxt = w_guard;
                end else if (r_counter == 8'd0) begin
                    w_state_nxt        = ST_ON;
                    w_cur_idx_nxt      = w_idx;
                    w_switch_count_nxt = r_switch_count + 16'd1;
                    w_irq_nxt          = w_irq_en;
                end else begin
                    w_counter_nxt = r_counter - 8'd1;
                end
            end
            ST_ON: begin
                if (w_ctrl_chg) begin
                    if (w_valid) begin
                        w_state_nxt   = ST_DRAIN;
                        w_counter_nxt = w_guard;
                    end else begin
                        w_state_nxt   = ST_OFF;
                    end
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    always_comb begin
        w_active = '0;
        if (r_state == ST_ON) begin
            for (int i = 0; i < NUM_PROJECTS; i++) begin
                w_active[i] = (r_cur_idx == i[3:0]);
            end
        end
    end

    assign active_o = w_active;
    assign irq_o    = r_irq;

endmodule

// File: tb/tb_wb_project_select.sv
// Bench for wb_project_select: directed scenarios followed by randomized
// register traffic, checked against a register-level model of the selector.
module tb_wb_project_select;

    localparam int          NP   = 8;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]    sel = '0;
    logic [31:0]   adr = '0, dat = '0;
    logic          ack;
    logic [31:0]   dat_o;
    logic [NP-1:0] active;
    logic          irq;

    int checks = 0;
    int failures = 0;
    int irq_cnt = 0;
    logic prev_ack = 1'b0, prev_irq = 1'b0;

    // Register-level model
    logic [3:0]  m_idx;
    logic        m_en, m_irq_en;
    logic [7:0]  m_guard;
    logic [3:0]  m_cur;
    logic        m_on;
    logic [15:0] m_swcnt;

    wb_project_select #(.NUM_PROJECTS(NP), .BASE_ADDR(BASE), .RESET_GUARD(8'd4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .active_o  (active),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP-1:0] onehot(input logic [3:0] i);
        logic [NP-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic m_valid();
        return m_en && (m_idx < NP);
    endfunction

    task automatic model_reset();
        m_idx = '0; m_en = 1'b0; m_irq_en = 1'b0; m_guard = 8'd4;
        m_cur = '0; m_on = 1'b0; m_swcnt = '0;
    endtask

    // Invariants observed every cycle, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot", 32'($countones(active) <= 1), 32'd1);
            chk("ack_gap", {31'd0, ack & prev_ack}, 32'd0);
            if (irq) begin
                chk("irq_width", {31'd0, prev_irq}, 32'd0);
                irq_cnt++;
            end
            prev_ack = ack;
            prev_irq = irq;
        end else begin
            prev_ack = 1'b0;
            prev_irq = 1'b0;
        end
    end

    // One Wishbone access; the ack must arrive on the first edge and last one cycle.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
        tick();
        chk("ack_rise", {31'd0, ack}, 32'd1);
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        chk("ack_single", {31'd0, ack}, 32'd0);
        chk("dat_idle", dat_o, 32'd0);
    endtask

    task automatic check_regs();
        logic [31:0] r;
        logic inv;
        inv = m_en && !(m_idx < NP);
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, r);
        chk("status", r, {m_swcnt, 5'd0, inv, 1'b0, m_on, 4'd0, m_cur});
        xfer(1'b0, BASE + 32'h0, 32'd0, 4'hF, r);
        chk("ctrl_rd", r, {22'd0, m_irq_en, m_en, 4'd0, m_idx});
        xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, r);
        chk("guard_rd", r, {24'd0, m_guard});
    endtask

    task automatic wr_guard(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        xfer(1'b1, BASE + 32'h4, d, s, r);
        if (s[0]) m_guard = d[7:0];
    endtask

    // CTRL write from a settled state; checks the resulting switch timing.
    task automatic wr_ctrl(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic [3:0]  old_idx;
        logic        old_en, was_on, changed;
        int          irq0;
        old_idx = m_idx; old_en = m_en; was_on = m_on; irq0 = irq_cnt;
        xfer(1'b1, BASE + 32'h0, d, s, r);
        if (s[0]) m_idx = d[3:0];
        if (s[1]) begin m_en = d[8]; m_irq_en = d[9]; end
        changed = (m_idx != old_idx) || (m_en != old_en);
        if (m_valid() && (changed || !was_on)) begin
            // guard+1 all-zero cycles, then the new project
            chk("gap_start", 32'(active), 32'd0);
            for (int i = 0; i < int'(m_guard); i++) begin
                tick();
                chk("gap", 32'(active), 32'd0);
            end
            tick();
            m_cur = m_idx; m_on = 1'b1; m_swcnt = m_swcnt + 16'd1;
            chk("switch_on", 32'(active), 32'(onehot(m_cur)));
            tick();
            chk("irq_count", 32'(irq_cnt - irq0), {31'd0, m_irq_en});
        end else if (!m_valid()) begin
            m_on = 1'b0;
            chk("off", 32'(active), 32'd0);
            repeat (3) tick();
            chk("off_hold", 32'(active), 32'd0);
            chk("irq_none", 32'(irq_cnt - irq0), 32'd0);
        end else begin
            repeat (3) tick();
            chk("hold", 32'(active), 32'(onehot(m_cur)));
            chk("irq_none", 32'(irq_cnt - irq0), 32'd0);
        end
        check_regs();
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] d;
        logic [31:0] a;
        int          irq0;
        int          op;

        model_reset();
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Identification and reset GUARD
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, r);
        chk("id", r, 32'h5052_4A53);
        xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, r);
        chk("guard_reset", r, 32'd4);
        check_regs();

        // First selection with GUARD=4
        wr_ctrl(32'h0000_0101, 4'hF);
        // Switch 1 -> 2 with GUARD=0 and irq enabled
        wr_guard(32'd0, 4'hF);
        wr_ctrl(32'h0000_0302, 4'hF);
        // Out-of-range index
        wr_ctrl(32'h0000_0309, 4'hF);

        // Retarget during DRAIN
        wr_guard(32'd6, 4'hF);
        xfer(1'b1, BASE + 32'h0, 32'h0000_0103, 4'hF, r);
        m_idx = 4'd3; m_en = 1'b1; m_irq_en = 1'b0;
        repeat (2) tick();
        chk("drain_zero", 32'(active), 32'd0);
        wr_ctrl(32'h0000_0105, 4'hF);
        // Lane 1 only: idx must stay 5
        wr_ctrl(32'h0000_0107, 4'b0010);
        // Writes to read-only registers
        xfer(1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, r);
        xfer(1'b1, BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, r);
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, r);
        chk("id_ro", r, 32'h5052_4A53);
        check_regs();

        // Randomized register traffic
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 5) begin
                d = $urandom;
                d[3:0] = 4'($urandom_range(0, 11));
                wr_ctrl(d, 4'($urandom_range(0, 15)));
            end else if (op <= 7) begin
                d = $urandom;
                d[7:0] = 8'($urandom_range(0, 5));
                wr_guard(d, 4'($urandom_range(0, 15)));
                check_regs();
            end else if (op == 8) begin
                if ($urandom_range(0, 1) == 1)
                    a = BASE + 32'h10 * 32'($urandom_range(1, 4));
                else
                    a = BASE ^ (32'd1 << $urandom_range(4, 31));
                cyc = 1'b1; stb = 1'b1; we = 1'($urandom_range(0, 1));
                adr = a; dat = $urandom; sel = 4'hF;
                repeat (3) begin
                    tick();
                    chk("no_ack_oow", {31'd0, ack}, 32'd0);
                end
                cyc = 1'b0; stb = 1'b0; we = 1'b0;
                tick();
                check_regs();
            end else begin
                xfer(1'b0, BASE + 32'hC + 32'($urandom_range(0, 3)), 32'd0, 4'hF, r);
                chk("id_rand", r, 32'h5052_4A53);
            end
        end

        // Reset in the middle of DRAIN
        wr_guard(32'd6, 4'hF);
        d = 32'h0000_0300 | 32'((m_idx + 4'd1) % 4'd8);
        xfer(1'b1, BASE + 32'h0, d, 4'hF, r);
        tick();
        irq0 = irq_cnt;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_dat", dat_o, 32'd0);
        chk("mid_rst_active", 32'(active), 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        model_reset();
        repeat (12) tick();
        chk("post_rst_irq", 32'(irq_cnt - irq0), 32'd0);
        chk("post_rst_active", 32'(active), 32'd0);
        check_regs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
